// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// slot FSM encoding and default timing constants.
package disp_scan_ctrl_pkg;

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

    localparam int DEF_N_DIGITS = 4;
    localparam int DEF_CLK_DIV  = 50000;
    localparam int DEF_DEAD_CYC = 2;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Host-side load bus plus the scanned display outputs of disp_scan_ctrl.
interface disp_scan_ctrl_if
    import disp_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   data_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    lzs_en;
    logic [3:0]              digit_hex;
    logic [N_DIGITS-1:0]     digit_sel_n;
    logic                    dp_n;
    logic                    frame_done;

    modport master (
        output load, data_in, dp_in, lzs_en,
        input  digit_hex, digit_sel_n, dp_n, frame_done
    );

    modport slave (
        input  load, data_in, dp_in, lzs_en,
        output digit_hex, digit_sel_n, dp_n, frame_done
    );
endinterface

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..CLK_DIV-1, flags the last cycle of a slot and
// whether the following cycle falls inside the anode-off dead window.
module scan_tick_gen
    import disp_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int DEAD_CYC = DEF_DEAD_CYC
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,
    output logic dead_next
);
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign slot_end  = (cnt_reg == CNT_W'(CLK_DIV - 1));
    assign cnt_next  = slot_end ? '0 : cnt_reg + 1'b1;
    // Look-ahead so the parent can register outputs aligned with the count.
    assign dead_next = (cnt_next < CNT_W'(DEAD_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digit data committed
// at frame end, dead-time between slots, optional leading-zero suppression.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int DEAD_CYC = DEF_DEAD_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    disp_scan_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic                  slot_end;
    logic                  dead_next;
    slot_state_t           state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [4*N_DIGITS-1:0] disp_reg, disp_next, shadow_disp_reg;
    logic [N_DIGITS-1:0]   dp_reg, dp_next, shadow_dp_reg;
    logic                  lzs_reg, lzs_next, shadow_lzs_reg;
    logic                  pending_reg;
    logic                  frame_end, commit;
    logic [N_DIGITS:0]     upper_zero;
    logic [N_DIGITS-1:0]   supp_next;
    logic [N_DIGITS-1:0]   sel_next;
    logic [3:0]            digit_hex_reg;
    logic [N_DIGITS-1:0]   digit_sel_n_reg;
    logic                  dp_n_reg;
    logic                  frame_done_reg;

    scan_tick_gen #(
        .CLK_DIV  (CLK_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_end  (slot_end),
        .dead_next (dead_next)
    );

    assign frame_end = slot_end && (idx_reg == IDX_LAST);
    // A load in the frame's last cycle bypasses the shadow straight into the commit.
    assign commit    = frame_end && (pending_reg || bus.load);
    assign disp_next = !commit ? disp_reg : (bus.load ? bus.data_in : shadow_disp_reg);
    assign dp_next   = !commit ? dp_reg   : (bus.load ? bus.dp_in   : shadow_dp_reg);
    assign lzs_next  = !commit ? lzs_reg  : (bus.load ? bus.lzs_en  : shadow_lzs_reg);
    assign idx_next  = !slot_end ? idx_reg : ((idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1);

    // upper_zero[k]: nibbles k..N_DIGITS-1 of the next display word are all zero.
    assign upper_zero[N_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lzs
            assign upper_zero[gi] = (disp_next[4*gi +: 4] == 4'd0) && upper_zero[gi+1];
            assign supp_next[gi]  = (gi != 0) && lzs_next && upper_zero[gi] && !dp_next[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_DEAD:  if (!dead_next) state_next = ST_DRIVE;
            ST_DRIVE: if (slot_end)   state_next = ST_DEAD;
            default:  state_next = ST_DEAD;
        endcase
    end

    always_comb begin
        sel_next = '1;
        if (state_next == ST_DRIVE && !supp_next[idx_next]) begin
            sel_next[idx_next] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_DEAD;
            idx_reg         <= '0;
            disp_reg        <= '0;
            dp_reg          <= '0;
            lzs_reg         <= 1'b0;
            shadow_disp_reg <= '0;
            shadow_dp_reg   <= '0;
            shadow_lzs_reg  <= 1'b0;
            pending_reg     <= 1'b0;
            digit_hex_reg   <= 4'd0;
            digit_sel_n_reg <= '1;
            dp_n_reg        <= 1'b1;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            disp_reg  <= disp_next;
            dp_reg    <= dp_next;
            lzs_reg   <= lzs_next;
            if (bus.load) begin
                shadow_disp_reg <= bus.data_in;
                shadow_dp_reg   <= bus.dp_in;
                shadow_lzs_reg  <= bus.lzs_en;
            end
            pending_reg     <= commit ? 1'b0 : (pending_reg || bus.load);
            digit_hex_reg   <= disp_next[{idx_next, 2'b00} +: 4];
            digit_sel_n_reg <= sel_next;
            dp_n_reg        <= (state_next == ST_DRIVE) ? ~dp_next[idx_next] : 1'b1;
            frame_done_reg  <= frame_end;
        end
    end

    assign bus.digit_hex   = digit_hex_reg;
    assign bus.digit_sel_n = digit_sel_n_reg;
    assign bus.dp_n        = dp_n_reg;
    assign bus.frame_done  = frame_done_reg;
endmodule
